// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared constants and types for the instruction fetch stage and its
// two-entry skid FIFO.
//   ROM_ADDRESS_BITWIDTH_DEFAULT : byte-address width of PC / ROM address
//   RESET_PC_DEFAULT             : PC loaded on reset (4-byte aligned)
//   fifo_count_t                 : FIFO occupancy, 0..FIFO_DEPTH
//   fifo_op_e                    : {push, pop} request decode for the FIFO
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int unsigned ROM_ADDRESS_BITWIDTH_DEFAULT = 15;
  localparam int unsigned RESET_PC_DEFAULT             = 0;
  localparam int unsigned INSTR_W                      = 32;
  localparam int unsigned PC_STEP                      = 4;
  localparam int unsigned FIFO_DEPTH                   = 2;
  localparam int unsigned COUNT_W                      = 2;

  typedef logic [COUNT_W-1:0] fifo_count_t;

  // Encoding matches the concatenation {push, pop}.
  typedef enum logic [1:0] {
    FIFO_IDLE     = 2'b00,
    FIFO_POP      = 2'b01,
    FIFO_PUSH     = 2'b10,
    FIFO_PUSH_POP = 2'b11
  } fifo_op_e;

endpackage : fetch_unit_pkg

// File: rtl/fetch_skid_fifo.sv
// -----------------------------------------------------------------------------
// fetch_skid_fifo
// Two-entry FIFO that decouples the ROM's fixed read latency from decode
// backpressure. The head always lives in entry0_q, so the head output is a
// plain register with no read-pointer mux.
//   clk, reset_n   : clock, asynchronous active-low reset
//   push_i         : write push_data_i at the next edge
//   pop_i          : discard the head at the next edge
//   flush_i        : empty the FIFO (dominates push and pop)
//   count_o        : occupancy, 0..2
//   head_o         : oldest entry (meaningful when count_o != 0)
// -----------------------------------------------------------------------------
module fetch_skid_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DATA_W = ROM_ADDRESS_BITWIDTH_DEFAULT + INSTR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output fifo_count_t       count_o,
  output logic [DATA_W-1:0] head_o
);

  fifo_count_t       count_q, count_d;
  logic [DATA_W-1:0] entry0_q, entry0_d;
  logic [DATA_W-1:0] entry1_q, entry1_d;
  fifo_op_e          op;

  assign op = fifo_op_e'({push_i, pop_i});

  // NOTE: every variable gets its hold value first so no path through the
  // case below leaves it unassigned, which would infer a latch.
  always_comb begin
    count_d  = count_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;

    if (flush_i) begin
      count_d = '0;
    end else begin
      unique case (op)
        FIFO_PUSH: begin
          if (count_q == 2'd0) begin
            entry0_d = push_data_i;
            count_d  = 2'd1;
          end else if (count_q == 2'd1) begin
            entry1_d = push_data_i;
            count_d  = 2'd2;
          end
          // A push into a full FIFO is dropped; the issue logic upstream
          // never lets that happen.
        end
        FIFO_POP: begin
          if (count_q != 2'd0) begin
            entry0_d = entry1_q;
            count_d  = count_q - 2'd1;
          end
        end
        FIFO_PUSH_POP: begin
          if (count_q == 2'd2) begin
            // Head leaves, second entry moves up, new data goes behind it.
            entry0_d = entry1_q;
            entry1_d = push_data_i;
          end else begin
            // With one entry the pushed word becomes the new head directly.
            entry0_d = push_data_i;
            count_d  = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the storage entries are reset as well, not just the count, because
  // the head drives out_pc/out_instr directly and those must read 0 in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      count_q  <= count_d;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = entry0_q;

endmodule : fetch_skid_fifo

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage in front of a ROM with one-cycle registered reads.
// Owns the PC, tracks which ROM word is live, and hands (pc, instr) pairs to
// decode over valid/ready. A redirect flushes both the buffered entries and
// the fetch currently in the ROM.
//   clk, reset_n         : clock, asynchronous active-low reset
//   rom_address          : byte address presented to the ROM (= pc_q)
//   rom_data             : ROM word for the address latched last edge
//   redirect_valid/_pc   : load a new PC (low two bits ignored)
//   out_valid/out_ready  : decode handshake
//   out_instr, out_pc    : instruction and its byte address (FIFO head)
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ROM_ADDRESS_BITWIDTH = ROM_ADDRESS_BITWIDTH_DEFAULT,
  parameter int unsigned RESET_PC             = RESET_PC_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset_n,
  output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_address,
  input  logic [INSTR_W-1:0]              rom_data,
  input  logic                            redirect_valid,
  input  logic [ROM_ADDRESS_BITWIDTH-1:0] redirect_pc,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [INSTR_W-1:0]              out_instr,
  output logic [ROM_ADDRESS_BITWIDTH-1:0] out_pc
);

  localparam int unsigned W       = ROM_ADDRESS_BITWIDTH;
  localparam int unsigned ENTRY_W = W + INSTR_W;
  localparam logic [W-1:0] RESET_PC_ALIGNED = W'(RESET_PC & 32'hFFFF_FFFC);
  localparam logic [W-1:0] PC_INC           = W'(PC_STEP);

  logic [W-1:0]       pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [W-1:0]       inflight_pc_q, inflight_pc_d;

  fifo_count_t        count;
  logic [ENTRY_W-1:0] head;
  logic               pop;
  logic               push;
  logic               issue;
  logic [2:0]         occupancy;
  logic               unused_redirect_low;

  // Redirect targets are word aligned; the byte offset is dropped.
  assign unused_redirect_low = ^redirect_pc[1:0];

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  // The live ROM word is captured unless a redirect has killed it.
  assign push = inflight_q & ~redirect_valid;

  // Entries that will be buffered or in flight after this edge if nothing
  // new is issued. Issuing only while this is at most 1 keeps the two-entry
  // FIFO from overflowing even if decode then stalls.
  assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = ~redirect_valid & (occupancy <= 3'd1);

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;

    if (redirect_valid) begin
      pc_d = {redirect_pc[W-1:2], 2'b00};
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + PC_INC;  // wraps modulo 2^W
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC_ALIGNED;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // When an issue is suppressed the ROM re-reads pc_q; that word is ignored
  // because inflight_q is cleared for it.
  assign rom_address = pc_q;

  fetch_skid_fifo #(
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i ({inflight_pc_q, rom_data}),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .count_o     (count),
    .head_o      (head)
  );

  assign {out_pc, out_instr} = head;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int W = 15;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] rom_address;
  logic [31:0]  rom_data = '0;
  logic         redirect_valid = 1'b0;
  logic [W-1:0] redirect_pc = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_instr;
  logic [W-1:0] out_pc;

  int checks   = 0;
  int failures = 0;

  // Expected byte address of the next instruction decode will accept.
  logic [W-1:0] exp_pc;

  // Outputs observed in the current cycle.
  logic         s_valid;
  logic [W-1:0] s_pc;
  logic [W-1:0] s_addr;
  logic [31:0]  s_instr;

  fetch_unit u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rom_address    (rom_address),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  // ROM contents: word[i] = 0x1000_0000 + i.
  function automatic logic [31:0] rom_word(input logic [W-1:0] a);
    return 32'h1000_0000 + {19'd0, a[W-1:2]};
  endfunction

  // Registered-read ROM: data for the address present at an edge appears
  // after that edge.
  always @(posedge clk) rom_data <= rom_word(rom_address);

  // Apply inputs for the coming rising edge on the falling edge, then sample
  // the outputs produced by the previous rising edge.
  task automatic drive(input logic rdy, input logic rv, input logic [W-1:0] rpc);
    @(negedge clk);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    s_valid = out_valid;
    s_pc    = out_pc;
    s_instr = out_instr;
    s_addr  = rom_address;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== '0 || out_instr !== 32'h0 || rom_address !== '0) begin
      failures++;
      $display("FAIL reset_state: valid=%b pc=%h instr=%h addr=%h, required 0/0/0/0",
               out_valid, out_pc, out_instr, rom_address);
    end
    reset_n = 1'b1;
    // After E0: RESET_PC issued, nothing visible yet.
    drive(1'b1, 1'b0, '0);
    checks++;
    if (s_valid !== 1'b0 || s_addr !== 15'h0004) begin
      failures++;
      $display("FAIL startup_e0: valid=%b addr=%h, required valid=0 addr=0004", s_valid, s_addr);
    end
    // After E1: first instruction visible.
    drive(1'b1, 1'b0, '0);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 15'h0000 || s_instr !== rom_word(15'h0000)) begin
      failures++;
      $display("FAIL startup_e1: valid=%b pc=%h instr=%h, required 1/0000/%h",
               s_valid, s_pc, s_instr, rom_word(15'h0000));
    end
    exp_pc = 15'h0004;
  endtask

  task automatic test_stream(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, '0);
      checks++;
      if (s_valid !== 1'b1 || s_pc !== exp_pc || s_instr !== rom_word(exp_pc)) begin
        failures++;
        $display("FAIL stream: valid=%b pc=%h instr=%h, required 1/%h/%h",
                 s_valid, s_pc, s_instr, exp_pc, rom_word(exp_pc));
      end
      exp_pc = exp_pc + 15'd4;
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] hold_addr;
    drive(1'b0, 1'b0, '0);
    hold_addr = s_addr;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, '0);
      checks++;
      if (s_valid !== 1'b1 || s_pc !== exp_pc || s_instr !== rom_word(exp_pc) ||
          s_addr !== hold_addr) begin
        failures++;
        $display("FAIL backpressure_hold: valid=%b pc=%h instr=%h addr=%h, required 1/%h/%h/%h",
                 s_valid, s_pc, s_instr, s_addr, exp_pc, rom_word(exp_pc), hold_addr);
      end
    end
    test_stream(10);
  endtask

  task automatic test_redirect_full();
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 15'h0102);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== exp_pc) begin
      failures++;
      $display("FAIL redirect_full_pre: valid=%b pc=%h, required 1/%h", s_valid, s_pc, exp_pc);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, '0);
      checks++;
      if (s_valid !== 1'b0) begin
        failures++;
        $display("FAIL redirect_full_gap: valid=%b pc=%h, required valid=0", s_valid, s_pc);
      end
    end
    exp_pc = 15'h0100;
    test_stream(6);
  endtask

  task automatic test_redirect_pop();
    drive(1'b1, 1'b1, 15'h0200);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== exp_pc || s_instr !== rom_word(exp_pc)) begin
      failures++;
      $display("FAIL redirect_pop_consumed: valid=%b pc=%h, required 1/%h", s_valid, s_pc, exp_pc);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, '0);
      checks++;
      if (s_valid !== 1'b0) begin
        failures++;
        $display("FAIL redirect_pop_gap: valid=%b pc=%h, required valid=0", s_valid, s_pc);
      end
    end
    exp_pc = 15'h0200;
    test_stream(4);
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 15'h7FFC);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== exp_pc) begin
      failures++;
      $display("FAIL wrap_pre: valid=%b pc=%h, required 1/%h", s_valid, s_pc, exp_pc);
    end
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_gap: valid=%b, required 0", s_valid);
    end
    exp_pc = 15'h7FFC;
    test_stream(3);
    checks++;
    if (exp_pc !== 15'h0008) begin
      failures++;
      $display("FAIL wrap_model: next pc %h, required 0008", exp_pc);
    end
  endtask

  task automatic test_async_reset();
    test_stream(3);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== '0 || out_instr !== 32'h0 || rom_address !== '0) begin
      failures++;
      $display("FAIL async_reset: valid=%b pc=%h instr=%h addr=%h, required 0/0/0/0",
               out_valid, out_pc, out_instr, rom_address);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 1'b0, '0);
    checks++;
    if (s_valid !== 1'b0 || s_addr !== 15'h0004) begin
      failures++;
      $display("FAIL restart_e0: valid=%b addr=%h, required valid=0 addr=0004", s_valid, s_addr);
    end
    drive(1'b1, 1'b0, '0);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 15'h0000 || s_instr !== rom_word(15'h0000)) begin
      failures++;
      $display("FAIL restart_e1: valid=%b pc=%h instr=%h, required 1/0000/%h",
               s_valid, s_pc, s_instr, rom_word(15'h0000));
    end
    exp_pc = 15'h0004;
    test_stream(3);
  endtask

  // Random ready/redirect traffic against an in-order stream model: every
  // accepted instruction must be the next sequential pc since the last
  // redirect, with the ROM word for that pc.
  task automatic test_random(input int n);
    logic         rdy, rv;
    logic [W-1:0] rpc;
    logic         prev_valid, prev_rdy, prev_rv;
    logic [W-1:0] prev_pc;
    logic [31:0]  prev_instr;
    int           since_rd;
    prev_valid = 1'b0;
    prev_rdy   = 1'b0;
    prev_rv    = 1'b0;
    prev_pc    = '0;
    prev_instr = '0;
    since_rd   = 100;
    for (int i = 0; i < n; i++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = W'($urandom_range(0, (1 << W) - 1));
      drive(rdy, rv, rpc);
      if (since_rd < 100) since_rd++;
      if (since_rd == 1 || since_rd == 2) begin
        checks++;
        if (s_valid !== 1'b0) begin
          failures++;
          $display("FAIL rand_redirect_gap: cycle %0d valid=%b, required 0", since_rd, s_valid);
        end
      end else if (since_rd == 3) begin
        checks++;
        if (s_valid !== 1'b1) begin
          failures++;
          $display("FAIL rand_redirect_latency: valid=%b, required 1", s_valid);
        end
      end
      if (prev_valid && !prev_rdy && !prev_rv) begin
        checks++;
        if (s_valid !== 1'b1 || s_pc !== prev_pc || s_instr !== prev_instr) begin
          failures++;
          $display("FAIL rand_stable: valid=%b pc=%h instr=%h, required 1/%h/%h",
                   s_valid, s_pc, s_instr, prev_pc, prev_instr);
        end
      end
      if (s_valid && rdy) begin
        checks++;
        if (s_pc !== exp_pc || s_instr !== rom_word(exp_pc)) begin
          failures++;
          $display("FAIL rand_order: pc=%h instr=%h, required %h/%h",
                   s_pc, s_instr, exp_pc, rom_word(exp_pc));
        end
        exp_pc = exp_pc + 15'd4;
      end
      if (rv) begin
        exp_pc   = {rpc[W-1:2], 2'b00};
        since_rd = 0;
      end
      prev_valid = s_valid;
      prev_rdy   = rdy;
      prev_rv    = rv;
      prev_pc    = s_pc;
      prev_instr = s_instr;
    end
  endtask

  initial begin
    test_reset();
    test_stream(12);
    test_backpressure();
    test_redirect_full();
    test_redirect_pop();
    test_wrap();
    test_async_reset();
    test_random(600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule : tb_fetch_unit
